// File: rtl/axis_seq_transmitter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : axis_seq_transmitter_pkg                                     |
// | Description : Shared AXI4-Stream field types and the transmitter FSM      |
// |               state encoding.                                              |
// | Contents    : axi_data_t (64b), axi_dest_t (4b), axi_id_t (4b),            |
// |               axis_tx_state_t                                              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package axis_seq_transmitter_pkg;

  localparam int AXI_DATA_W = 64;
  localparam int AXI_DEST_W = 4;
  localparam int AXI_ID_W   = 4;

  typedef logic [AXI_DATA_W-1:0] axi_data_t;
  typedef logic [AXI_DEST_W-1:0] axi_dest_t;
  typedef logic [AXI_ID_W-1:0]   axi_id_t;

  typedef enum logic [1:0] {
    AXIS_TX_IDLE = 2'd0,
    AXIS_TX_SEND = 2'd1,
    AXIS_TX_GAP  = 2'd2
  } axis_tx_state_t;

endpackage
`default_nettype wire

// File: rtl/axis_seq_transmitter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : axis_seq_transmitter_if                                      |
// | Description : AXI4-Stream bundle (tvalid/tready/tdata/tlast/tid/tdest).    |
// | Modports    : master - drives tvalid, tdata, tlast, tid, tdest; reads      |
// |                        tready                                              |
// |               slave  - the mirror image                                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface axis_seq_transmitter_if;
  import axis_seq_transmitter_pkg::*;

  logic      tvalid;
  logic      tready;
  axi_data_t tdata;
  logic      tlast;
  axi_id_t   tid;
  axi_dest_t tdest;

  modport master (
    output tvalid,
    output tdata,
    output tlast,
    output tid,
    output tdest,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tdata,
    input  tlast,
    input  tid,
    input  tdest,
    output tready
  );

endinterface
`default_nettype wire

// File: rtl/axis_seq_transmitter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : axis_seq_transmitter                                         |
// | Description : On a start pulse, sends one AXI4-Stream packet of LEN beats  |
// |               carrying BASE_DATA + beat_index to a latched destination,   |
// |               honouring tready backpressure and optional idle gaps        |
// |               between beats.                                               |
// | Ports       : clk, rst       - clock, async active-high reset             |
// |               axis (master)  - AXI4-Stream output                          |
// |               start_i        - one-cycle packet request (ignored if busy)  |
// |               dest_i         - destination, sampled when start accepted    |
// |               busy_o         - packet in flight                            |
// |               done_o         - one-cycle pulse after the last handshake    |
// |               pkt_count_o    - completed packets, wrapping 16-bit count    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module axis_seq_transmitter
  import axis_seq_transmitter_pkg::*;
#(
  parameter axi_id_t     ID         = '0,
  parameter int unsigned LEN        = 24,
  parameter axi_data_t   BASE_DATA  = 64'hdeadbeef00000000,
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  axis_seq_transmitter_if.master axis,
  input  logic                   start_i,
  input  axi_dest_t              dest_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [15:0]            pkt_count_o
);

  localparam int BEAT_W = (LEN == 0) ? 1 : $clog2(LEN + 1);
  localparam int GAP_W  = (GAP_CYCLES == 0) ? 1 : $clog2(GAP_CYCLES + 1);

  generate
    if (LEN == 0) begin : g_len_check
      $error("axis_seq_transmitter: LEN must be at least 1");
    end
  endgenerate

  axis_tx_state_t    state_q;
  logic [BEAT_W-1:0] beat_q;
  logic [GAP_W-1:0]  gap_q;
  logic              tvalid_q;
  logic              tlast_q;
  axi_data_t         tdata_q;
  axi_dest_t         tdest_q;
  logic              busy_q;
  logic              done_q;
  logic [15:0]       pkt_count_q;

  logic [BEAT_W-1:0] beat_d;
  axi_data_t         tdata_d;
  logic              tlast_d;
  logic              handshake;

  assign handshake = tvalid_q && axis.tready;

  // Values for the beat that follows the one currently presented.
  // tdata wraps naturally modulo 2^64.
  assign beat_d  = beat_q + 1'b1;
  assign tdata_d = BASE_DATA + axi_data_t'(beat_d);
  assign tlast_d = (beat_d == BEAT_W'(LEN - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= AXIS_TX_IDLE;
      beat_q      <= '0;
      gap_q       <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      tdata_q     <= '0;
      tdest_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pkt_count_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        AXIS_TX_IDLE: begin
          if (start_i) begin
            tdest_q  <= dest_i;
            beat_q   <= '0;
            tdata_q  <= BASE_DATA;
            tvalid_q <= 1'b1;
            tlast_q  <= (LEN == 1);
            busy_q   <= 1'b1;
            state_q  <= AXIS_TX_SEND;
          end
        end

        AXIS_TX_SEND: begin
          // Without a handshake every output simply holds.
          if (handshake) begin
            if (tlast_q) begin
              tvalid_q    <= 1'b0;
              tlast_q     <= 1'b0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              pkt_count_q <= pkt_count_q + 16'd1;
              state_q     <= AXIS_TX_IDLE;
            end else begin
              beat_q  <= beat_d;
              tdata_q <= tdata_d;
              tlast_q <= tlast_d;
              if (GAP_CYCLES != 0) begin
                tvalid_q <= 1'b0;
                gap_q    <= GAP_W'(GAP_CYCLES);
                state_q  <= AXIS_TX_GAP;
              end
            end
          end
        end

        AXIS_TX_GAP: begin
          // Raising tvalid as the counter leaves 1 gives exactly GAP_CYCLES
          // idle cycles between the handshake and the next presented beat.
          if (gap_q <= GAP_W'(1)) begin
            gap_q    <= '0;
            tvalid_q <= 1'b1;
            state_q  <= AXIS_TX_SEND;
          end else begin
            gap_q <= gap_q - 1'b1;
          end
        end

        default: begin
          state_q <= AXIS_TX_IDLE;
        end
      endcase
    end
  end

  assign axis.tvalid = tvalid_q;
  assign axis.tdata  = tdata_q;
  assign axis.tlast  = tlast_q;
  assign axis.tdest  = tdest_q;
  assign axis.tid    = ID;

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign pkt_count_o = pkt_count_q;

endmodule
`default_nettype wire

// File: tb/tb_axis_seq_transmitter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_axis_seq_transmitter                                      |
// | Description : Self-checking bench for axis_seq_transmitter. Four DUTs     |
// |               cover the parameter sets (LEN=24, gap 0 / gap 2, LEN=1 and  |
// |               LEN=2 with all-ones base). One DUT at a time is selected;   |
// |               its beats are collected and compared with a packet model.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_axis_seq_transmitter;
  import axis_seq_transmitter_pkg::*;

  localparam axi_data_t BASE_A = 64'hdeadbeef00000000;
  localparam axi_data_t BASE_B = 64'hffffffffffffffff;
  localparam axi_id_t   ID0    = 4'h3;
  localparam axi_id_t   ID1    = 4'h5;
  localparam axi_id_t   ID2    = 4'h0;
  localparam axi_id_t   ID3    = 4'ha;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int sel    = 0;
  int exp_cnt [4];

  logic      start_drv  = 1'b0;
  logic      tready_drv = 1'b0;
  axi_dest_t dest_drv   = '0;

  logic        busy0, busy1, busy2, busy3;
  logic        done0, done1, done2, done3;
  logic [15:0] pkt0, pkt1, pkt2, pkt3;

  axis_seq_transmitter_if if0 ();
  axis_seq_transmitter_if if1 ();
  axis_seq_transmitter_if if2 ();
  axis_seq_transmitter_if if3 ();

  assign if0.tready = tready_drv && (sel == 0);
  assign if1.tready = tready_drv && (sel == 1);
  assign if2.tready = tready_drv && (sel == 2);
  assign if3.tready = tready_drv && (sel == 3);

  axis_seq_transmitter #(.ID(ID0), .LEN(24), .BASE_DATA(BASE_A), .GAP_CYCLES(0)) u0 (
    .clk(clk), .rst(rst), .axis(if0), .start_i(start_drv && (sel == 0)),
    .dest_i(dest_drv), .busy_o(busy0), .done_o(done0), .pkt_count_o(pkt0));
  axis_seq_transmitter #(.ID(ID1), .LEN(24), .BASE_DATA(BASE_A), .GAP_CYCLES(2)) u1 (
    .clk(clk), .rst(rst), .axis(if1), .start_i(start_drv && (sel == 1)),
    .dest_i(dest_drv), .busy_o(busy1), .done_o(done1), .pkt_count_o(pkt1));
  axis_seq_transmitter #(.ID(ID2), .LEN(1), .BASE_DATA(BASE_B), .GAP_CYCLES(0)) u2 (
    .clk(clk), .rst(rst), .axis(if2), .start_i(start_drv && (sel == 2)),
    .dest_i(dest_drv), .busy_o(busy2), .done_o(done2), .pkt_count_o(pkt2));
  axis_seq_transmitter #(.ID(ID3), .LEN(2), .BASE_DATA(BASE_B), .GAP_CYCLES(0)) u3 (
    .clk(clk), .rst(rst), .axis(if3), .start_i(start_drv && (sel == 3)),
    .dest_i(dest_drv), .busy_o(busy3), .done_o(done3), .pkt_count_o(pkt3));

  // Outputs of the currently selected DUT.
  logic        mon_tvalid, mon_tlast, mon_busy, mon_done;
  axi_data_t   mon_tdata;
  axi_dest_t   mon_tdest;
  axi_id_t     mon_tid;
  logic [15:0] mon_pkt;

  always_comb begin
    mon_tvalid = 1'b0; mon_tlast = 1'b0; mon_busy = 1'b0; mon_done = 1'b0;
    mon_tdata  = '0;   mon_tdest = '0;   mon_tid  = '0;   mon_pkt  = '0;
    case (sel)
      0: begin
        mon_tvalid = if0.tvalid; mon_tlast = if0.tlast; mon_tdata = if0.tdata;
        mon_tdest = if0.tdest; mon_tid = if0.tid; mon_busy = busy0; mon_done = done0; mon_pkt = pkt0;
      end
      1: begin
        mon_tvalid = if1.tvalid; mon_tlast = if1.tlast; mon_tdata = if1.tdata;
        mon_tdest = if1.tdest; mon_tid = if1.tid; mon_busy = busy1; mon_done = done1; mon_pkt = pkt1;
      end
      2: begin
        mon_tvalid = if2.tvalid; mon_tlast = if2.tlast; mon_tdata = if2.tdata;
        mon_tdest = if2.tdest; mon_tid = if2.tid; mon_busy = busy2; mon_done = done2; mon_pkt = pkt2;
      end
      default: begin
        mon_tvalid = if3.tvalid; mon_tlast = if3.tlast; mon_tdata = if3.tdata;
        mon_tdest = if3.tdest; mon_tid = if3.tid; mon_busy = busy3; mon_done = done3; mon_pkt = pkt3;
      end
    endcase
  end

  // Collected transfer record of the last packet.
  axi_data_t got_data [$];
  logic      got_last [$];
  axi_dest_t got_dest [$];
  axi_id_t   got_tid  [$];
  int        hs_cyc   [$];
  logic      vpat     [$];

  // Starts a packet on the selected DUT, collects beats until done, and
  // compares them with the expected packet: beat i = base + i, tlast on the
  // final beat, tdest = d, tid = id. Returns in the negedge where done is seen.
  task automatic run_pkt(input string name, input int len, input axi_data_t base,
                         input axi_id_t id, input axi_dest_t d, input int ready_pct,
                         input int restart_at);
    int        cyc;
    bit        seen_done;
    bit        pulsed;
    bit        prev_stall;
    axi_data_t prev_data;
    axi_dest_t prev_dest;
    logic      prev_last;
    axi_data_t exp_data;
    got_data.delete(); got_last.delete(); got_dest.delete(); got_tid.delete();
    hs_cyc.delete(); vpat.delete();
    start_drv = 1'b1; dest_drv = d; tready_drv = 1'b0;
    @(negedge clk);
    start_drv = 1'b0; dest_drv = axi_dest_t'($urandom);
    checks++;
    if (mon_tvalid !== 1'b1 || mon_busy !== 1'b1) begin
      errors++;
      $display("FAIL %s start_latency: tvalid=%b busy=%b, required 1 1", name, mon_tvalid, mon_busy);
    end
    cyc = 0; seen_done = 0; pulsed = 0; prev_stall = 0;
    prev_data = '0; prev_dest = '0; prev_last = 1'b0;
    while (!seen_done && cyc < 1000) begin
      start_drv = 1'b0;
      if (mon_done === 1'b1) begin
        seen_done = 1;
      end else begin
        vpat.push_back(mon_tvalid);
        if (prev_stall) begin
          checks++;
          if (mon_tvalid !== 1'b1 || mon_tdata !== prev_data || mon_tdest !== prev_dest ||
              mon_tlast !== prev_last) begin
            errors++;
            $display("FAIL %s stall_hold cyc %0d: tvalid=%b tdata=%h tdest=%h, required 1 %h %h",
                     name, cyc, mon_tvalid, mon_tdata, mon_tdest, prev_data, prev_dest);
          end
        end
        if (restart_at >= 0 && !pulsed && got_data.size() == restart_at) begin
          start_drv = 1'b1; dest_drv = 4'h3; pulsed = 1;
        end
        tready_drv = ($urandom_range(0, 99) < ready_pct);
        if (mon_tvalid && tready_drv) begin
          got_data.push_back(mon_tdata); got_last.push_back(mon_tlast);
          got_dest.push_back(mon_tdest); got_tid.push_back(mon_tid);
          hs_cyc.push_back(cyc);
        end
        prev_stall = mon_tvalid && !tready_drv;
        prev_data = mon_tdata; prev_dest = mon_tdest; prev_last = mon_tlast;
        @(negedge clk);
        cyc++;
      end
    end
    tready_drv = 1'b0;
    checks++;
    if (!seen_done) begin
      errors++;
      $display("FAIL %s done_timeout: no done after %0d cycles, required done", name, cyc);
    end
    checks++;
    if (got_data.size() != len) begin
      errors++;
      $display("FAIL %s beat_count: got %0d, required %0d", name, got_data.size(), len);
    end
    for (int i = 0; i < got_data.size() && i < len; i++) begin
      exp_data = base + axi_data_t'(i);
      checks++;
      if (got_data[i] !== exp_data || got_last[i] !== (i == len - 1) ||
          got_dest[i] !== d || got_tid[i] !== id) begin
        errors++;
        $display("FAIL %s beat %0d: data=%h last=%b dest=%h tid=%h, required %h %b %h %h",
                 name, i, got_data[i], got_last[i], got_dest[i], got_tid[i],
                 exp_data, (i == len - 1), d, id);
      end
    end
    if (seen_done) begin
      exp_cnt[sel] = (exp_cnt[sel] + 1) % 65536;
      checks++;
      if (mon_busy !== 1'b0 || mon_tvalid !== 1'b0 || mon_tlast !== 1'b0 ||
          mon_pkt !== 16'(exp_cnt[sel])) begin
        errors++;
        $display("FAIL %s done_state: busy=%b tvalid=%b tlast=%b pkt=%0d, required 0 0 0 %0d",
                 name, mon_busy, mon_tvalid, mon_tlast, mon_pkt, exp_cnt[sel]);
      end
    end
  endtask

  // One cycle after done: pulse gone, nothing restarted.
  task automatic check_quiet(input string name);
    @(negedge clk);
    checks++;
    if (mon_done !== 1'b0 || mon_busy !== 1'b0 || mon_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL %s after_done: done=%b busy=%b tvalid=%b, required 0 0 0",
               name, mon_done, mon_busy, mon_tvalid);
    end
  endtask

  task automatic test_reset();
    axi_id_t ids [4];
    ids = '{ID0, ID1, ID2, ID3};
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      sel = s;
      #1;
      checks++;
      if (mon_tvalid !== 1'b0 || mon_tlast !== 1'b0 || mon_tdata !== '0 || mon_tdest !== '0 ||
          mon_busy !== 1'b0 || mon_done !== 1'b0 || mon_pkt !== 16'd0 || mon_tid !== ids[s]) begin
        errors++;
        $display("FAIL reset dut%0d: tvalid=%b tlast=%b tdata=%h tdest=%h busy=%b done=%b pkt=%0d tid=%h, required zeros tid=%h",
                 s, mon_tvalid, mon_tlast, mon_tdata, mon_tdest, mon_busy, mon_done, mon_pkt, mon_tid, ids[s]);
      end
      exp_cnt[s] = 0;
    end
    @(negedge clk);
    rst = 1'b0;
    sel = 0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    sel = 0;
    run_pkt("basic", 24, BASE_A, ID0, 4'h2, 100, -1);
    check_quiet("basic");
  endtask

  task automatic test_backpressure();
    sel = 0;
    run_pkt("backpressure", 24, BASE_A, ID0, 4'h2, 50, -1);
    check_quiet("backpressure");
  endtask

  task automatic test_ignored_start();
    sel = 0;
    run_pkt("ignored_start", 24, BASE_A, ID0, 4'h2, 100, 5);
    check_quiet("ignored_start");
  endtask

  // First packet: a start coinciding with the last handshake is ignored.
  // Second packet: start in the same cycle as done is accepted.
  task automatic test_back_to_back();
    sel = 0;
    run_pkt("b2b_first", 24, BASE_A, ID0, 4'h6, 100, 23);
    run_pkt("b2b_second", 24, BASE_A, ID0, 4'h9, 80, -1);
    check_quiet("b2b_second");
  endtask

  task automatic test_gap();
    int last_hs;
    sel = 1;
    run_pkt("gap", 24, BASE_A, ID1, 4'h2, 100, -1);
    checks++;
    if (vpat.size() != 70) begin
      errors++;
      $display("FAIL gap cycle_span: got %0d cycles, required 70", vpat.size());
    end
    for (int i = 0; i < vpat.size(); i++) begin
      checks++;
      if (vpat[i] !== (i % 3 == 0)) begin
        errors++;
        $display("FAIL gap tvalid_pattern cyc %0d: got %b, required %b", i, vpat[i], (i % 3 == 0));
      end
    end
    last_hs = (hs_cyc.size() > 0) ? hs_cyc[hs_cyc.size() - 1] : -1;
    checks++;
    if (last_hs != 69) begin
      errors++;
      $display("FAIL gap last_handshake: got cycle %0d, required 69", last_hs);
    end
    check_quiet("gap");
  endtask

  task automatic test_reset_mid();
    int n;
    int guard;
    sel = 0;
    start_drv = 1'b1; dest_drv = 4'h2;
    @(negedge clk);
    start_drv = 1'b0; tready_drv = 1'b1;
    n = 0; guard = 0;
    while (n < 10 && guard < 100) begin
      if (mon_tvalid) n++;
      @(negedge clk);
      guard++;
    end
    checks++;
    if (mon_tvalid !== 1'b1 || mon_tdata !== BASE_A + 64'd10) begin
      errors++;
      $display("FAIL reset_mid beat10: tvalid=%b tdata=%h, required 1 %h", mon_tvalid, mon_tdata, BASE_A + 64'd10);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (mon_tvalid !== 1'b0 || mon_busy !== 1'b0 || mon_pkt !== 16'd0 || mon_tdata !== '0 ||
        mon_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid async_clear: tvalid=%b busy=%b pkt=%0d tdata=%h done=%b, required 0 0 0 0 0",
               mon_tvalid, mon_busy, mon_pkt, mon_tdata, mon_done);
    end
    for (int s = 0; s < 4; s++) exp_cnt[s] = 0;
    tready_drv = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_pkt("after_reset", 24, BASE_A, ID0, 4'h2, 100, -1);
    check_quiet("after_reset");
  endtask

  task automatic test_len1_wrap();
    sel = 2;
    run_pkt("len1_a", 1, BASE_B, ID2, 4'h1, 100, -1);
    check_quiet("len1_a");
    run_pkt("len1_b", 1, BASE_B, ID2, 4'h4, 60, -1);
    checks++;
    if (mon_pkt !== 16'd2) begin
      errors++;
      $display("FAIL len1 pkt_count: got %0d, required 2", mon_pkt);
    end
    check_quiet("len1_b");
    sel = 3;
    run_pkt("len2_wrap", 2, BASE_B, ID3, 4'h7, 70, -1);
    checks++;
    if (got_data.size() != 2 || got_data[got_data.size() - 1] !== 64'd0) begin
      errors++;
      $display("FAIL len2 wrap_beat1: size=%0d last_data=%h, required 2 0000000000000000",
               got_data.size(), (got_data.size() > 0) ? got_data[got_data.size() - 1] : 64'hx);
    end
    check_quiet("len2_wrap");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_ignored_start();
    test_back_to_back();
    test_gap();
    test_reset_mid();
    test_len1_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
